// File: rtl/scsi_hba_n.sv
// scsi_hba_n: 5380-style SCSI host adapter with an N-target bus merge,
// a loadable DMA byte counter with end-of-DMA, and an interrupt unit
// (end-of-DMA, phase mismatch, busy loss, bus reset).
// Optional target parity checking is built when SCSI_HBA_PARITY_EN is defined.
module scsi_hba_n #(
    parameter int NUM_TGT = 2,
    parameter int CNT_W   = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 ce,
    input  logic                 bus_cs,
    input  logic                 bus_we,
    input  logic [2:0]           bus_rs,
    input  logic                 dack,
    input  logic [7:0]           wdata,
    output logic [7:0]           rdata,
    output logic                 irq,
    output logic                 drq,
    input  logic [CNT_W-1:0]     dma_len,
    input  logic                 dma_len_ld,
    input  logic [NUM_TGT-1:0]   tgt_bsy,
    input  logic [NUM_TGT-1:0]   tgt_msg,
    input  logic [NUM_TGT-1:0]   tgt_cd,
    input  logic [NUM_TGT-1:0]   tgt_io,
    input  logic [NUM_TGT-1:0]   tgt_req,
    input  logic [8*NUM_TGT-1:0] tgt_dout,
`ifdef SCSI_HBA_PARITY_EN
    input  logic [NUM_TGT-1:0]   tgt_par,
    output logic                 scsi_par,
`endif
    output logic                 scsi_rst,
    output logic                 scsi_sel,
    output logic                 scsi_atn,
    output logic                 scsi_ack,
    output logic [7:0]           scsi_dout
);

    typedef enum logic [1:0] {D_IDLE, D_REQ, D_ACK} dstate_t;

    dstate_t          state_q, state_d;
    logic [7:0]       mr_q, mr_d;
    logic [5:0]       icr_q, icr_d;      // {icr7, icr4..icr0}
    logic [3:0]       tcr_q, tcr_d;
    logic [7:0]       dout_q, dout_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             irq_q, irq_d;
    logic             eodma_q, eodma_d;
    logic             perr_q, perr_d;
    logic             dma_en_q, dma_en_d;
    logic             dma_ack_q;
    logic             cs_q, req_q, bsy_q;

    logic       msg, cd, io, req, sel_par;
    logic [7:0] din;
    logic       acc, dma_wr, dma_rd, reg_wr, reg_rd;
    logic       scsi_bsy, pmatch, req_rise;

    // Merge targets: the lowest busy index owns the bus (assigned last, so it wins)
    always_comb begin
        msg     = 1'b0;
        cd      = 1'b0;
        io      = 1'b0;
        req     = 1'b0;
        sel_par = 1'b0;
        din     = 8'h55;
        for (int i = NUM_TGT - 1; i >= 0; i--) begin
            if (tgt_bsy[i]) begin
                msg = tgt_msg[i];
                cd  = tgt_cd[i];
                io  = tgt_io[i];
                req = tgt_req[i];
                din = tgt_dout[8*i +: 8];
`ifdef SCSI_HBA_PARITY_EN
                sel_par = tgt_par[i];
`endif
            end
        end
    end

    // One pulse per access; dack/we decode makes the four pulses mutually exclusive
    assign acc    = bus_cs & ~cs_q;
    assign dma_wr = acc & dack & bus_we;
    assign dma_rd = acc & dack & ~bus_we;
    assign reg_wr = acc & ~dack & bus_we;
    assign reg_rd = acc & ~dack & ~bus_we;

    assign scsi_bsy = icr_q[3] | mr_q[0] | (|tgt_bsy);
    assign pmatch   = (tcr_q[2:0] == {msg, cd, io});
    assign req_rise = req & ~req_q;

    assign irq       = irq_q;
    assign drq       = (state_q == D_REQ) & req & pmatch;
    assign scsi_rst  = icr_q[5];
    assign scsi_sel  = icr_q[2];
    assign scsi_atn  = icr_q[1];
    assign scsi_ack  = icr_q[4] | dma_ack_q;
    assign scsi_dout = dout_q;
`ifdef SCSI_HBA_PARITY_EN
    assign scsi_par  = ~^dout_q;
`endif

    // Register read mux; dack reads always see the CDR
    always_comb begin
        logic [7:0] cdr;
        cdr   = (icr_q[0] | mr_q[0]) ? dout_q : din;
        rdata = cdr;
        if (!dack) begin
            case (bus_rs)
                3'd0:    rdata = cdr;
                3'd1:    rdata = {icr_q[5], mr_q[0], 1'b0, icr_q[4:0]};
                3'd2:    rdata = mr_q;
                3'd3:    rdata = {4'h0, tcr_q};
                3'd4:    rdata = {icr_q[5], scsi_bsy, req, msg, cd, io, icr_q[2], sel_par};
                3'd5:    rdata = {eodma_q, drq, perr_q, irq_q, pmatch, 1'b0, icr_q[1], scsi_ack};
                3'd6:    rdata = din;
                default: rdata = 8'hff;
            endcase
        end
    end

    // Next state: register writes, DMA FSM, counter and interrupt sources
    always_comb begin
        state_d  = state_q;
        mr_d     = mr_q;
        icr_d    = icr_q;
        tcr_d    = tcr_q;
        dout_d   = dout_q;
        cnt_d    = cnt_q;
        irq_d    = irq_q;
        eodma_d  = eodma_q;
        perr_d   = perr_q;
        dma_en_d = dma_en_q;

        if (reg_wr) begin
            case (bus_rs)
                3'd0:    dout_d = wdata;
                3'd1:    icr_d  = {wdata[7], wdata[4:0]};
                3'd2:    mr_d   = wdata;
                3'd3:    tcr_d  = wdata[3:0];
                3'd4:    ;
                default: dma_en_d = mr_q[1];
            endcase
        end

        // Status clear comes first so any same-cycle interrupt set wins
        if (reg_rd && bus_rs == 3'd7) begin
            irq_d   = 1'b0;
            eodma_d = 1'b0;
            perr_d  = 1'b0;
        end

        case (state_q)
            D_IDLE: if (dma_en_q) state_d = D_REQ;
            D_REQ: begin
                if (dma_wr) dout_d = wdata;
                if ((dma_rd | dma_wr) & req) state_d = D_ACK;
            end
            D_ACK: begin
                if (!req) begin
                    state_d = D_REQ;
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - 1'b1;
                        if (cnt_q == CNT_W'(1)) begin
                            eodma_d  = 1'b1;
                            dma_en_d = 1'b0;
                            state_d  = D_IDLE;
                            if (mr_q[3]) irq_d = 1'b1;
                        end
                    end
                end
            end
            default: state_d = D_IDLE;
        endcase

        if (req_rise && dma_en_q && !pmatch) begin
            irq_d    = 1'b1;
            dma_en_d = 1'b0;
            state_d  = D_IDLE;
        end
        if (mr_q[2] && bsy_q && !scsi_bsy) irq_d = 1'b1;
        if (reg_wr && bus_rs == 3'd1 && wdata[7] && !icr_q[5]) irq_d = 1'b1;
`ifdef SCSI_HBA_PARITY_EN
        if (dma_rd && !(^{sel_par, din})) begin
            perr_d = 1'b1;
            if (mr_q[5]) irq_d = 1'b1;
        end
`endif
        // Leaving DMA mode aborts any transfer in the same clock as the MR write
        if (!mr_d[1]) begin
            dma_en_d = 1'b0;
            state_d  = D_IDLE;
        end
        if (dma_len_ld) cnt_d = dma_len;
    end

    // State and edge-detect registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= D_IDLE;
            mr_q     <= '0;
            icr_q    <= '0;
            tcr_q    <= '0;
            dout_q   <= '0;
            cnt_q    <= '0;
            irq_q    <= 1'b0;
            eodma_q  <= 1'b0;
            perr_q   <= 1'b0;
            dma_en_q <= 1'b0;
            cs_q     <= 1'b0;
            req_q    <= 1'b0;
            bsy_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            mr_q     <= mr_d;
            icr_q    <= icr_d;
            tcr_q    <= tcr_d;
            dout_q   <= dout_d;
            cnt_q    <= cnt_d;
            irq_q    <= irq_d;
            eodma_q  <= eodma_d;
            perr_q   <= perr_d;
            dma_en_q <= dma_en_d;
            cs_q     <= bus_cs;
            req_q    <= req;
            bsy_q    <= scsi_bsy;
        end
    end

    // DMA ACK follows the FSM only on ce clocks; reset releases it at once
    always_ff @(posedge clk) begin
        if (reset)   dma_ack_q <= 1'b0;
        else if (ce) dma_ack_q <= (state_q == D_ACK);
    end

endmodule
